seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed N-digit 7-segment display driver; successor to the single-digit combinational BCD decoder.
- Scans NUM_DIGITS digits one at a time from a prescaled clock, decodes BCD (optionally hex), blanks leading zeros and drives the decimal points.
- Uses frame-synchronous double buffering so a displayed frame never tears.
- Sits between the datapath (value producer) and the board-level segment/anode pins.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_decode.sv | 15 +
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display drivers: segment table (a..g, MSB = a)
// and the width helper for digit indices.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD/hex to 7-segment decoder; codes 10..15 blank unless hex_en.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_en,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_TABLE[code];
      if (!hex_en && (code > 4'd9)) seg = SEG_BLANK;
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous double buffering,
// leading-zero blanking, anti-ghosting dead time and pin polarity control.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned CLK_DIV     = 1000,
   parameter int unsigned DEAD_CYCLES = 1,
   parameter bit          HEX_EN      = 1'b0,
   parameter bit          LZ_BLANK    = 1'b1,
   parameter bit          SEG_ACT_LOW = 1'b0,
   parameter bit          AN_ACT_LOW  = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic                               load,
   input  logic [4*NUM_DIGITS-1:0]            value,
   input  logic [NUM_DIGITS-1:0]              dp_in,
   output logic [6:0]                         seg,
   output logic                               dp,
   output logic [NUM_DIGITS-1:0]              an,
   output logic [idx_width(NUM_DIGITS)-1:0]   digit_idx,
   output logic                               frame_done
);

   localparam int unsigned IW = idx_width(NUM_DIGITS);
   localparam int unsigned PW = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
   localparam int unsigned VW = 4 * NUM_DIGITS;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] DEAD_LEN   = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]         presc;
   logic [VW-1:0]         shadow_val, active_val;
   logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
   logic                  pending;
   logic [6:0]            seg_q, dec_seg;
   logic                  dp_q;
   logic [NUM_DIGITS-1:0] an_q, an_next, an_gated;
   logic [3:0]            cur_code;
   logic                  cur_dp, cur_blank, zero_run;

   assign frame_done = enable && (presc == PRESC_LAST) && (digit_idx == IDX_LAST);

   // Walk digits from the most significant down so zero_run covers "this and all higher".
   always_comb begin
      cur_code  = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      an_next   = '0;
      zero_run  = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         int unsigned k;
         k = NUM_DIGITS - 1 - i;
         zero_run = zero_run && (active_val[k*4 +: 4] == 4'd0);
         if (IW'(k) == digit_idx) begin
            cur_code   = active_val[k*4 +: 4];
            cur_dp     = active_dp[k];
            cur_blank  = LZ_BLANK && (k != 0) && zero_run;
            an_next[k] = (presc >= DEAD_LEN);
         end
      end
   end

   seg7_decode u_decode (
      .code   (cur_code),
      .hex_en (HEX_EN),
      .seg    (dec_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc      <= '0;
         digit_idx  <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
         pending    <= 1'b0;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b0;
         an_q       <= '0;
      end else begin
         if (enable) begin
            if (presc == PRESC_LAST) begin
               presc     <= '0;
               digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
               presc <= presc + 1'b1;
            end
         end
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
         end
         // A load landing on the frame boundary bypasses the shadow so it is not lost.
         if (load && frame_done) begin
            active_val <= value;
            active_dp  <= dp_in;
            pending    <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end else if (frame_done && pending) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
            pending    <= 1'b0;
         end
         seg_q <= cur_blank ? SEG_BLANK : dec_seg;
         dp_q  <= cur_dp;
         an_q  <= an_next;
      end
   end

   // Anodes are gated by enable directly so a paused scan goes dark immediately.
   assign an_gated = enable ? an_q : '0;
   assign an       = AN_ACT_LOW  ? ~an_gated : an_gated;
   assign seg      = SEG_ACT_LOW ? ~seg_q    : seg_q;
   assign dp       = SEG_ACT_LOW ? ~dp_q     : dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a decimal instance and a hex, active-low-segment
// instance share stimulus and run in lockstep.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n, enable, load;
   logic [15:0] value;
   logic [3:0]  dp_in;

   logic [6:0]  a_seg, h_seg, h_seg_n;
   logic        a_dp, h_dp, h_dp_n;
   logic [3:0]  a_an, h_an;
   logic [1:0]  a_idx, h_idx;
   logic        a_fd, h_fd;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign h_seg_n = ~h_seg;
   assign h_dp_n  = ~h_dp;

   seg7_scan_driver #(
      .NUM_DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_EN(1'b0),
      .LZ_BLANK(1'b1), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .seg(a_seg), .dp(a_dp), .an(a_an), .digit_idx(a_idx),
      .frame_done(a_fd)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(4), .CLK_DIV(4), .DEAD_CYCLES(1), .HEX_EN(1'b1),
      .LZ_BLANK(1'b1), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b0)
   ) dut_h (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .seg(h_seg), .dp(h_dp), .an(h_an), .digit_idx(h_idx),
      .frame_done(h_fd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   // Returns one negedge after the frame_done cycle, i.e. aligned to a frame start.
   task automatic wait_frame_done();
      int n = 0;
      while (!a_fd && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!a_fd) check("frame_done_wait", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   // Checks one full frame slot by slot; optional loads are issued at iteration l1r/l2r.
   task automatic scan_frame(input string tag, input logic [27:0] ea, input logic [27:0] eh,
                             input logic [3:0] edp,
                             input int l1r, input logic [15:0] l1v, input logic [3:0] l1d,
                             input int l2r, input logic [15:0] l2v, input logic [3:0] l2d);
      logic [3:0] exp_an;
      int s, ph;
      for (int r = 0; r < 16; r++) begin
         if (r == l1r) begin
            value = l1v; dp_in = l1d; load = 1'b1;
         end else if (r == l2r) begin
            value = l2v; dp_in = l2d; load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
         s  = r / 4;
         ph = r % 4;
         exp_an = (ph == 0) ? 4'b0000 : (4'b0001 << s);
         check($sformatf("%s an r%0d", tag, r), a_an, exp_an);
         check($sformatf("%s h_an r%0d", tag, r), h_an, exp_an);
         check($sformatf("%s seg r%0d", tag, r), a_seg, ea[s*7 +: 7]);
         check($sformatf("%s h_seg r%0d", tag, r), h_seg_n, eh[s*7 +: 7]);
         check($sformatf("%s dp r%0d", tag, r), a_dp, edp[s]);
         check($sformatf("%s h_dp r%0d", tag, r), h_dp_n, edp[s]);
         check($sformatf("%s frame_done r%0d", tag, r), a_fd, (r == 14));
         check($sformatf("%s digit_idx r%0d", tag, r), a_idx, ((r + 1) / 4) % 4);
      end
      load = 1'b0;
   endtask

   localparam logic [27:0] E_1234 = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
   localparam logic [27:0] E_0070 = {7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110};
   localparam logic [27:0] E_0000 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110};
   localparam logic [27:0] E_AF_H = {7'b0000000, 7'b0000000, 7'b1110111, 7'b1000111};
   localparam logic [27:0] E_2222 = {4{7'b1101101}};
   localparam logic [27:0] E_5678 = {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};

   initial begin
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;

      @(negedge clk);
      check("rst seg", a_seg, 7'b0000000);
      check("rst h_seg", h_seg, 7'b1111111);
      check("rst an", a_an, 4'b0000);
      check("rst dp", a_dp, 1'b0);
      check("rst h_dp", h_dp, 1'b1);
      check("rst frame_done", a_fd, 1'b0);
      check("rst digit_idx", a_idx, 2'd0);
      rst_n  = 1'b1;
      enable = 1'b1;

      do_load(16'h1234, 4'b0100);
      wait_frame_done();
      scan_frame("f1234", E_1234, E_1234, 4'b0100, -1, '0, '0, -1, '0, '0);

      do_load(16'h0070, 4'b0000);
      wait_frame_done();
      scan_frame("f0070", E_0070, E_0070, 4'b0000, -1, '0, '0, -1, '0, '0);

      do_load(16'h0000, 4'b0000);
      wait_frame_done();
      scan_frame("f0000", E_0000, E_0000, 4'b0000, -1, '0, '0, -1, '0, '0);

      do_load(16'h00AF, 4'b0000);
      wait_frame_done();
      scan_frame("f00AF", 28'd0, E_AF_H, 4'b0000, -1, '0, '0, -1, '0, '0);

      // Two loads inside a frame: display stays on old data, last load wins next frame.
      scan_frame("tear", 28'd0, E_AF_H, 4'b0000, 3, 16'h1111, 4'b0000, 8, 16'h2222, 4'b0000);
      // Load coinciding with frame_done goes straight to the following frame.
      scan_frame("f2222", E_2222, E_2222, 4'b0000, 15, 16'h5678, 4'b1010, -1, '0, '0);
      scan_frame("f5678", E_5678, E_5678, 4'b1010, -1, '0, '0, -1, '0, '0);

      // Pause mid-slot: state here is prescaler 1, digit 1.
      repeat (5) @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("pause an c%0d", i), a_an, 4'b0000);
         check($sformatf("pause frame_done c%0d", i), a_fd, 1'b0);
         check($sformatf("pause digit_idx c%0d", i), a_idx, 2'd1);
      end
      enable = 1'b1;
      @(negedge clk);
      check("resume an", a_an, 4'b0010);
      check("resume seg", a_seg, 7'b1110000);
      check("resume dp", a_dp, 1'b1);
      check("resume digit_idx", a_idx, 2'd1);
      repeat (2) @(negedge clk);
      check("resume digit_idx adv", a_idx, 2'd2);
      check("resume an last", a_an, 4'b0010);
      @(negedge clk);
      check("resume dead", a_an, 4'b0000);

      // Asynchronous reset between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check("async rst h_seg", h_seg, 7'b1111111);
      check("async rst h_an", h_an, 4'b0000);
      check("async rst an", a_an, 4'b0000);
      check("async rst seg", a_seg, 7'b0000000);
      check("async rst digit_idx", a_idx, 2'd0);
      check("async rst h_digit_idx", h_idx, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
